// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave with internal word-organised SRAM, configurable wait states and byte-lane writes.
// Define AHB_SRAM_STROBE_EN to qualify write byte lanes with Hstrob sampled in the closing cycle.
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  input  logic [ADDR_WIDTH-1:0]   Haddr,
  input  logic [1:0]              Htrans,
  input  logic                    Hwrite,
  input  logic [2:0]              Hsize,
  input  logic [2:0]              Hburst,
  input  logic [DATA_WIDTH-1:0]   HWdata,
  input  logic [DATA_WIDTH/8-1:0] Hstrob,
  input  logic                    Hsel,
  input  logic                    Hready,
  output logic [DATA_WIDTH-1:0]   HRdata,
  output logic                    Hreadyout,
  output logic [1:0]              Hresp
);

  localparam int BPW     = DATA_WIDTH / 8;
  localparam int LOG_BPW = $clog2(BPW);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [3:0]            wait_cnt;
  logic                  wr_q;
  logic [2:0]            size_q;
  logic [LOG_BPW-1:0]    off_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  open_slot, accept, legal;
  logic [ADDR_WIDTH-1:0] addr_idx, align_mask;
  logic [BPW-1:0]        size_lanes, lane_en;
  logic                  unused_inputs;

  // A new address phase can only be taken in cycles where this slave drives Hreadyout high.
  assign open_slot  = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign accept     = open_slot && Hsel && Hready && Htrans[1];
  assign addr_idx   = Haddr >> LOG_BPW;
  assign align_mask = ~({ADDR_WIDTH{1'b1}} << Hsize);
  assign legal      = (addr_idx < ADDR_WIDTH'(DEPTH)) && (Hsize <= 3'(LOG_BPW))
                   && ((Haddr & align_mask) == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (!accept)     state_nxt = ST_IDLE;
        else if (!legal) state_nxt = ST_ERR1;
        else             state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_LAST;
      end
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_LAST;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      size_q   <= 3'd0;
      off_q    <= '0;
      idx_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q     <= Hwrite;
        size_q   <= Hsize;
        off_q    <= Haddr[LOG_BPW-1:0];
        idx_q    <= addr_idx[IDX_W-1:0];
        wait_cnt <= WAIT_INIT;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Bytes covered by the captured size starting at the captured lane offset.
  always_comb begin
    size_lanes = '0;
    for (int b = 0; b < BPW; b++)
      if ((b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q)))
        size_lanes[b] = 1'b1;
  end

`ifdef AHB_SRAM_STROBE_EN
  assign lane_en       = size_lanes & Hstrob;
  assign unused_inputs = ^{Hburst, Htrans[0]};
`else
  assign lane_en       = size_lanes;
  assign unused_inputs = ^{Hburst, Htrans[0], Hstrob};
`endif

  // NOTE: the SRAM array is deliberately not reset; only control state is.
  always_ff @(posedge Hclk) begin
    if (state == ST_LAST && wr_q)
      for (int b = 0; b < BPW; b++)
        if (lane_en[b]) mem[idx_q][8*b +: 8] <= HWdata[8*b +: 8];
  end

  // Asynchronous read in LAST sees a write that closed on the previous edge, covering read-after-write.
  assign HRdata    = (state == ST_LAST && !wr_q) ? mem[idx_q] : '0;
  assign Hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
  assign Hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) behind a tiny decoder/mux, driven by a
// pipelined AHB master model with a reference-memory scoreboard.
module tb_ahb_sram_slave;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic        known;
    logic [31:0] rdata;
    logic [4:0]  waits;
  } exp_t;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize, Hburst;
  logic [31:0] HWdata;
  logic [3:0]  Hstrob;
  logic        sel;
  logic        Hsel0, Hsel3, Hready;
  logic [31:0] rdata0, rdata3, cur_rdata;
  logic        ready0, ready3;
  logic [1:0]  resp0, resp3, cur_resp;

  assign Hsel0     = !sel;
  assign Hsel3     = sel;
  assign Hready    = sel ? ready3 : ready0;
  assign cur_rdata = sel ? rdata3 : rdata0;
  assign cur_resp  = sel ? resp3 : resp0;

  always #5 Hclk = ~Hclk;

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata), .Hstrob(Hstrob), .Hsel(Hsel0),
    .Hready(Hready), .HRdata(rdata0), .Hreadyout(ready0), .Hresp(resp0));

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hsize(Hsize), .Hburst(Hburst), .HWdata(HWdata), .Hstrob(Hstrob), .Hsel(Hsel3),
    .Hready(Hready), .HRdata(rdata3), .Hreadyout(ready3), .Hresp(resp3));

  xfer_t       pending[$];
  exp_t        exp_q[$];
  xfer_t       dp;
  logic        dp_valid;
  int          dp_waits;
  logic [31:0] ref_mem [int];
  int          compared, mismatched;

  // Reference prediction; writes update the model as soon as the address phase is issued.
  task automatic predict(input xfer_t x, output exp_t e);
    logic [31:0] idx, w;
    int key, off;
    logic lane;
    idx     = x.addr >> 2;
    key     = (sel ? 65536 : 0) + int'(idx[15:0]);
    off     = int'(x.addr[1:0]);
    e.rd    = !x.wr;
    e.err   = (idx >= 32'(DEPTH)) || (x.size > 3'd2) || ((x.addr & ((32'd1 << x.size) - 32'd1)) != 0);
    e.waits = e.err ? 5'd1 : (sel ? 5'd3 : 5'd0);
    e.known = 1'b0;
    e.rdata = '0;
    if (!e.err && !x.wr && ref_mem.exists(key)) begin
      e.known = 1'b1;
      e.rdata = ref_mem[key];
    end
    if (!e.err && x.wr) begin
      w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
      for (int b = 0; b < 4; b++) begin
        lane = (b >= off) && (b < off + (1 << x.size));
`ifdef AHB_SRAM_STROBE_EN
        lane = lane && x.strb[b];
`endif
        if (lane) w[8*b +: 8] = x.wdata[8*b +: 8];
      end
      ref_mem[key] = w;
    end
  endtask

  // One bus cycle, called at the falling edge: check the current data phase, then present the next address phase.
  task automatic step();
    exp_t e;
    logic [31:0] want;
    logic rdy;
    rdy = Hready;
    if (dp_valid) begin
      HWdata = dp.wr ? dp.wdata : $urandom;
      Hstrob = dp.wr ? dp.strb : 4'($urandom_range(0, 15));
      e = exp_q[0];
      compared++;
      if (cur_resp !== (e.err ? 2'b01 : 2'b00)) begin
        mismatched++;
        $display("FAIL resp @%h: got %b want %b", dp.addr, cur_resp, e.err ? 2'b01 : 2'b00);
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        want = (e.rd && !e.err) ? e.rdata : 32'h0;
        compared++;
        if (dp_waits != int'(e.waits)) begin
          mismatched++;
          $display("FAIL wait_count @%h: got %0d want %0d", dp.addr, dp_waits, e.waits);
        end
        if (!(e.rd && !e.err && !e.known)) begin
          compared++;
          if (cur_rdata !== want) begin
            mismatched++;
            $display("FAIL rdata @%h: got %h want %h", dp.addr, cur_rdata, want);
          end
        end
        dp_valid = 1'b0;
      end else begin
        dp_waits++;
        compared++;
        if (cur_rdata !== 32'h0) begin
          mismatched++;
          $display("FAIL rdata_in_wait @%h: got %h want 0", dp.addr, cur_rdata);
        end
      end
    end else begin
      compared++;
      if (rdy !== 1'b1 || cur_resp !== 2'b00 || cur_rdata !== 32'h0) begin
        mismatched++;
        $display("FAIL idle_cycle: got ready=%b resp=%b rdata=%h want 1/00/0", rdy, cur_resp, cur_rdata);
      end
    end
    if (rdy && pending.size() > 0) begin
      dp     = pending.pop_front();
      Haddr  = dp.addr;
      Htrans = dp.trans;
      Hwrite = dp.wr;
      Hsize  = dp.size;
      Hburst = 3'($urandom_range(0, 7));
      if (dp.trans[1]) begin
        predict(dp, e);
        exp_q.push_back(e);
        dp_valid = 1'b1;
        dp_waits = 0;
      end
    end else begin
      Haddr  = $urandom;
      Htrans = 2'b00;
      Hwrite = 1'($urandom_range(0, 1));
      Hsize  = 3'($urandom_range(0, 2));
    end
  endtask

  task automatic run(output int cycles);
    cycles = 0;
    while ((pending.size() > 0 || dp_valid) && cycles < 500) begin
      @(negedge Hclk);
      cycles++;
      step();
    end
    if (pending.size() > 0 || dp_valid) begin
      compared++;
      mismatched++;
      $display("FAIL run_timeout: got %0d cycles want completion", cycles);
      pending.delete();
      exp_q.delete();
      dp_valid = 1'b0;
    end
  endtask

  task automatic q_wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input logic [3:0] st);
    pending.push_back('{addr: a, wr: 1'b1, size: s, trans: 2'b10, wdata: d, strb: st});
  endtask

  task automatic q_rd(input logic [31:0] a, input logic [2:0] s, input logic [1:0] t);
    pending.push_back('{addr: a, wr: 1'b0, size: s, trans: t, wdata: 32'h0, strb: 4'h0});
  endtask

  task automatic test_reset();
    Hresetn = 1'b0;
    repeat (3) @(negedge Hclk);
    compared += 2;
    if (ready0 !== 1'b1 || resp0 !== 2'b00 || rdata0 !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_ws0: got %b/%b/%h want 1/00/0", ready0, resp0, rdata0);
    end
    if (ready3 !== 1'b1 || resp3 !== 2'b00 || rdata3 !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_ws3: got %b/%b/%h want 1/00/0", ready3, resp3, rdata3);
    end
    Hresetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cycles, ws;
    ws = sel ? 3 : 0;
    q_wr(32'h10, 3'd2, 32'hDEADBEEF, 4'hF);
    q_rd(32'h10, 3'd2, 2'b10);
    run(cycles);
    compared++;
    if (cycles != 1 + 2 * (ws + 1)) begin
      mismatched++;
      $display("FAIL back_to_back_cycles: got %0d want %0d", cycles, 1 + 2 * (ws + 1));
    end
  endtask

  task automatic test_wait_states();
    int cycles;
    q_wr(32'h20, 3'd2, 32'hCAFEF00D, 4'hF);
    run(cycles);
    q_rd(32'h20, 3'd2, 2'b10);
    run(cycles);
    compared++;
    if (cycles != 5) begin
      mismatched++;
      $display("FAIL read_latency: got %0d want 5", cycles);
    end
  endtask

  task automatic test_byte_lanes();
    int cycles;
    q_wr(32'h10, 3'd2, 32'h11223344, 4'hF);
    q_wr(32'h13, 3'd0, 32'hAB5A5A5A, 4'hF);
    q_rd(32'h10, 3'd2, 2'b10);
    q_wr(32'h14, 3'd2, 32'h0, 4'hF);
    q_wr(32'h16, 3'd1, 32'hC0DE7777, 4'hF);
    q_wr(32'h15, 3'd0, 32'h9999E199, 4'hF);
    q_rd(32'h14, 3'd2, 2'b10);
    q_rd(32'h16, 3'd1, 2'b10);
    run(cycles);
  endtask

  task automatic test_errors();
    int cycles;
    q_wr(32'h00, 3'd2, 32'h600DCAFE, 4'hF);
    q_wr(32'h02, 3'd2, 32'hFFFFFFFF, 4'hF);
    q_wr(32'(DEPTH * 4), 3'd2, 32'h12345678, 4'hF);
    q_rd(32'(DEPTH * 4), 3'd2, 2'b10);
    q_rd(32'h01, 3'd1, 2'b10);
    q_wr(32'h00, 3'd3, 32'h0, 4'hF);
    q_rd(32'h00, 3'd2, 2'b10);
    run(cycles);
  endtask

  task automatic test_burst_idle();
    int cycles;
    for (int i = 0; i < 4; i++)
      pending.push_back('{addr: 32'h60 + 32'(4 * i), wr: 1'b1, size: 3'd2,
                          trans: (i == 0) ? 2'b10 : 2'b11, wdata: $urandom, strb: 4'hF});
    pending.push_back('{addr: 32'h60, wr: 1'b1, size: 3'd2, trans: 2'b01, wdata: 32'h0, strb: 4'hF});
    for (int i = 0; i < 4; i++) q_rd(32'h60 + 32'(4 * i), 3'd2, (i == 0) ? 2'b10 : 2'b11);
    run(cycles);
  endtask

  task automatic test_strobe();
    int cycles;
    q_wr(32'h40, 3'd2, 32'h0, 4'hF);
    q_wr(32'h40, 3'd2, 32'hFFFFFFFF, 4'b0101);
    q_rd(32'h40, 3'd2, 2'b10);
    q_wr(32'h44, 3'd2, 32'h12345678, 4'hF);
    q_wr(32'h44, 3'd2, 32'hFFFFFFFF, 4'h0);
    q_rd(32'h44, 3'd2, 2'b10);
    run(cycles);
  endtask

  task automatic test_reset_abort();
    int cycles;
    q_wr(32'h30, 3'd2, 32'h55AA55AA, 4'hF);
    run(cycles);
    @(negedge Hclk);
    Haddr = 32'h30; Htrans = 2'b10; Hwrite = 1'b1; Hsize = 3'd2;
    @(negedge Hclk);
    Htrans = 2'b00; HWdata = 32'hFFFF0000; Hstrob = 4'hF;
    compared++;
    if (Hready !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_in_wait: got ready=%b want 0", Hready);
    end
    @(negedge Hclk);
    Hresetn = 1'b0;
    #1;
    compared++;
    if (Hready !== 1'b1 || cur_resp !== 2'b00 || cur_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL abort_outputs: got %b/%b/%h want 1/00/0", Hready, cur_resp, cur_rdata);
    end
    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;
    q_rd(32'h30, 3'd2, 2'b10);
    run(cycles);
  endtask

  task automatic test_isolation();
    int cycles;
    q_rd(32'h50, 3'd2, 2'b10);
    q_rd(32'h60, 3'd2, 2'b10);
    run(cycles);
  endtask

  initial begin
    int cycles;
    compared = 0; mismatched = 0; dp_valid = 1'b0; dp_waits = 0; sel = 1'b0;
    Haddr = '0; Htrans = 2'b00; Hwrite = 1'b0; Hsize = 3'd0; Hburst = 3'd0;
    HWdata = '0; Hstrob = '0;
    test_reset();

    sel = 1'b0;
    test_back_to_back();
    test_byte_lanes();
    test_errors();
    test_burst_idle();
    test_strobe();
    q_wr(32'h50, 3'd2, 32'h0A0A0A0A, 4'hF);
    run(cycles);

    sel = 1'b1;
    test_wait_states();
    test_back_to_back();
    test_byte_lanes();
    test_errors();
    test_strobe();
    test_reset_abort();
    q_wr(32'h50, 3'd2, 32'h0B0B0B0B, 4'hF);
    q_wr(32'h60, 3'd2, 32'h0C0C0C0C, 4'hF);
    run(cycles);

    sel = 1'b0;
    test_isolation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
